// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: instruction field positions, ALU op encodings
// and the EX-stage control payload.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 4;

    localparam int unsigned RS_HI = 25;
    localparam int unsigned RS_LO = 21;
    localparam int unsigned RT_HI = 20;
    localparam int unsigned RT_LO = 16;
    localparam int unsigned RD_HI = 15;
    localparam int unsigned RD_LO = 11;
    localparam int unsigned IMM_W = 16;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 4'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB = 4'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_AND = 4'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_OR  = 4'd3;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR = 4'd4;
    localparam logic [ALUOP_W-1:0] ALUOP_NOR = 4'd5;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT = 4'd6;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL = 4'd7;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL = 4'd8;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA = 4'd9;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI = 4'd10;

    // Control bundle carried from ID into EX; all-zero is a bubble.
    typedef struct packed {
        logic                regWrite;
        logic                memRead;
        logic                memWrite;
        logic                memToReg;
        logic                aluSrc;
        logic [ALUOP_W-1:0]  aluOp;
    } exCtrl_t;

endpackage

// File: rtl/operand_bypass.sv
// Register operand select: $0 reads zero, a same-cycle write-back wins over
// the register-file read.
module operand_bypass
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [REG_W-1:0]  regAddr,
    input  logic [DATA_W-1:0] regData,
    input  logic              wbRegWrite,
    input  logic [REG_W-1:0]  wbWriteRegister,
    input  logic [DATA_W-1:0] wbWriteData,
    output logic [DATA_W-1:0] operand_c
);

    always_comb begin
        operand_c = regData;
        if (regAddr == REG_ZERO) begin
            operand_c = '0;
        end else if (wbRegWrite && (wbWriteRegister == regAddr)) begin
            operand_c = wbWriteData;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use stall detection,
// flush handling and a saturating count of inserted load-use bubbles.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [INSTR_W-1:0]  Instr_ID,
    input  logic                Valid_ID,
    input  logic [DATA_W-1:0]   ReadData1,
    input  logic [DATA_W-1:0]   ReadData2,
    input  logic                RegWrite_ID,
    input  logic                MemRead_ID,
    input  logic                MemWrite_ID,
    input  logic                MemToReg_ID,
    input  logic                ALUSrc_ID,
    input  logic                RegDst_ID,
    input  logic [ALUOP_W-1:0]  ALUOp_ID,
    input  logic                WB_RegWrite,
    input  logic [REG_W-1:0]    WB_WriteRegister,
    input  logic [DATA_W-1:0]   WB_WriteData,
    input  logic                Flush,
    output logic                Stall_ID,
    output logic                Valid_EX,
    output logic [DATA_W-1:0]   A_EX,
    output logic [DATA_W-1:0]   B_EX,
    output logic [DATA_W-1:0]   Imm_EX,
    output logic [REG_W-1:0]    Rs_EX,
    output logic [REG_W-1:0]    Rt_EX,
    output logic [REG_W-1:0]    Dest_EX,
    output logic                RegWrite_EX,
    output logic                MemRead_EX,
    output logic                MemWrite_EX,
    output logic                MemToReg_EX,
    output logic                ALUSrc_EX,
    output logic [ALUOP_W-1:0]  ALUOp_EX,
    output logic [CNT_W-1:0]    StallCount
);

    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] opA_c;
    logic [DATA_W-1:0] opB_c;
    exCtrl_t           ctrlId;
    exCtrl_t           ctrlEx;
    logic              bubble;
    logic [5:0]        unusedOpcode;

    assign rs           = Instr_ID[RS_HI:RS_LO];
    assign rt           = Instr_ID[RT_HI:RT_LO];
    assign dest         = RegDst_ID ? Instr_ID[RD_HI:RD_LO] : rt;
    assign imm          = {{(DATA_W-IMM_W){Instr_ID[IMM_W-1]}}, Instr_ID[IMM_W-1:0]};
    assign unusedOpcode = Instr_ID[INSTR_W-1:RS_HI+1];

    // Writes to $0 are dropped here so EX/MEM/WB never see them.
    assign ctrlId = '{
        regWrite: RegWrite_ID && (dest != REG_ZERO),
        memRead:  MemRead_ID,
        memWrite: MemWrite_ID,
        memToReg: MemToReg_ID,
        aluSrc:   ALUSrc_ID,
        aluOp:    ALUOp_ID
    };

    operand_bypass #(.DATA_W(DATA_W)) uBypassA (
        .regAddr         (rs),
        .regData         (ReadData1),
        .wbRegWrite      (WB_RegWrite),
        .wbWriteRegister (WB_WriteRegister),
        .wbWriteData     (WB_WriteData),
        .operand_c       (opA_c)
    );

    operand_bypass #(.DATA_W(DATA_W)) uBypassB (
        .regAddr         (rt),
        .regData         (ReadData2),
        .wbRegWrite      (WB_RegWrite),
        .wbWriteRegister (WB_WriteRegister),
        .wbWriteData     (WB_WriteData),
        .operand_c       (opB_c)
    );

    // Load in EX whose destination feeds the instruction sitting in ID.
    assign Stall_ID = Valid_ID && Valid_EX && ctrlEx.memRead && (Dest_EX != REG_ZERO)
                      && ((Dest_EX == rs) || (Dest_EX == rt));

    assign bubble = Flush || Stall_ID || !Valid_ID;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Valid_EX   <= 1'b0;
            ctrlEx     <= '0;
            A_EX       <= '0;
            B_EX       <= '0;
            Imm_EX     <= '0;
            Rs_EX      <= '0;
            Rt_EX      <= '0;
            Dest_EX    <= '0;
            StallCount <= '0;
        end else begin
            if (bubble) begin
                Valid_EX <= 1'b0;
                ctrlEx   <= '0;
            end else begin
                Valid_EX <= 1'b1;
                ctrlEx   <= ctrlId;
                A_EX     <= opA_c;
                B_EX     <= opB_c;
                Imm_EX   <= imm;
                Rs_EX    <= rs;
                Rt_EX    <= rt;
                Dest_EX  <= dest;
            end
            // A flushed stall is not a load-use bubble; counter sticks at all-ones.
            if (!Flush && Stall_ID && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_W'(1);
            end
        end
    end

    assign RegWrite_EX = ctrlEx.regWrite;
    assign MemRead_EX  = ctrlEx.memRead;
    assign MemWrite_EX = ctrlEx.memWrite;
    assign MemToReg_EX = ctrlEx.memToReg;
    assign ALUSrc_EX   = ctrlEx.aluSrc;
    assign ALUOp_EX    = ctrlEx.aluOp;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset and
// saturation sequences, then random traffic against a behavioural model.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SAT_W  = 3;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    logic [31:0] Instr_ID, ReadData1, ReadData2, WB_WriteData;
    logic        Valid_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID, ALUSrc_ID, RegDst_ID;
    logic [3:0]  ALUOp_ID;
    logic        WB_RegWrite, Flush;
    logic [4:0]  WB_WriteRegister;

    logic        Stall_ID, Valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX;
    logic [31:0] A_EX, B_EX, Imm_EX;
    logic [4:0]  Rs_EX, Rt_EX, Dest_EX;
    logic [3:0]  ALUOp_EX;
    logic [CNT_W-1:0] StallCount;

    logic        sStall_ID, sValid_EX, sRegWrite_EX, sMemRead_EX, sMemWrite_EX, sMemToReg_EX, sALUSrc_EX;
    logic [31:0] sA_EX, sB_EX, sImm_EX;
    logic [4:0]  sRs_EX, sRt_EX, sDest_EX;
    logic [3:0]  sALUOp_EX;
    logic [SAT_W-1:0] sStallCount;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Instr_ID(Instr_ID), .Valid_ID(Valid_ID),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
        .MemToReg_ID(MemToReg_ID), .ALUSrc_ID(ALUSrc_ID), .RegDst_ID(RegDst_ID), .ALUOp_ID(ALUOp_ID),
        .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister), .WB_WriteData(WB_WriteData),
        .Flush(Flush), .Stall_ID(Stall_ID), .Valid_EX(Valid_EX),
        .A_EX(A_EX), .B_EX(B_EX), .Imm_EX(Imm_EX), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Dest_EX(Dest_EX),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .MemToReg_EX(MemToReg_EX), .ALUSrc_EX(ALUSrc_EX), .ALUOp_EX(ALUOp_EX), .StallCount(StallCount)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(SAT_W)) dutSat (
        .Clk(Clk), .Rst_n(Rst_n), .Instr_ID(Instr_ID), .Valid_ID(Valid_ID),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
        .MemToReg_ID(MemToReg_ID), .ALUSrc_ID(ALUSrc_ID), .RegDst_ID(RegDst_ID), .ALUOp_ID(ALUOp_ID),
        .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister), .WB_WriteData(WB_WriteData),
        .Flush(Flush), .Stall_ID(sStall_ID), .Valid_EX(sValid_EX),
        .A_EX(sA_EX), .B_EX(sB_EX), .Imm_EX(sImm_EX), .Rs_EX(sRs_EX), .Rt_EX(sRt_EX), .Dest_EX(sDest_EX),
        .RegWrite_EX(sRegWrite_EX), .MemRead_EX(sMemRead_EX), .MemWrite_EX(sMemWrite_EX),
        .MemToReg_EX(sMemToReg_EX), .ALUSrc_EX(sALUSrc_EX), .ALUOp_EX(sALUOp_EX), .StallCount(sStallCount)
    );

    int checks = 0;
    int failures = 0;
    logic lastStall;

    // Behavioural model of what EX should hold.
    logic        mValid, mRw, mMr, mMw, mM2r, mAs;
    logic [31:0] mA, mB, mImm;
    logic [4:0]  mRs, mRt, mDest;
    logic [3:0]  mAlu;
    int          stalls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] pickOp(input logic [4:0] r, input logic [31:0] rd);
        if (r == 5'd0) return 32'd0;
        if (WB_RegWrite && WB_WriteRegister == r) return WB_WriteData;
        return rd;
    endfunction

    function automatic logic modelStall();
        return Valid_ID && mValid && mMr && (mDest != 5'd0)
               && (mDest == Instr_ID[25:21] || mDest == Instr_ID[20:16]);
    endfunction

    function automatic logic [31:0] satCount(input int n, input int maxv);
        return 32'((n > maxv) ? maxv : n);
    endfunction

    task automatic modelReset();
        mValid = 0; mRw = 0; mMr = 0; mMw = 0; mM2r = 0; mAs = 0; mAlu = 0;
        mA = 0; mB = 0; mImm = 0; mRs = 0; mRt = 0; mDest = 0; stalls = 0;
    endtask

    task automatic modelEdge();
        logic s;
        s = modelStall();
        if (Flush || s || !Valid_ID) begin
            if (!Flush && s) stalls++;
            mValid = 0; mRw = 0; mMr = 0; mMw = 0; mM2r = 0; mAs = 0; mAlu = 0;
        end else begin
            mValid = 1;
            mRs    = Instr_ID[25:21];
            mRt    = Instr_ID[20:16];
            mDest  = RegDst_ID ? Instr_ID[15:11] : Instr_ID[20:16];
            mA     = pickOp(mRs, ReadData1);
            mB     = pickOp(mRt, ReadData2);
            mImm   = 32'($signed(Instr_ID[15:0]));
            mRw    = RegWrite_ID && (mDest != 5'd0);
            mMr = MemRead_ID; mMw = MemWrite_ID; mM2r = MemToReg_ID; mAs = ALUSrc_ID; mAlu = ALUOp_ID;
        end
    endtask

    task automatic checkSet(input string tag, input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] dest, input logic [4:0] ctl, input logic [3:0] alu,
                            input logic [31:0] cnt, input logic [31:0] expCnt);
        check({tag, " valid"}, 32'(v), 32'(mValid));
        check({tag, " ctrl"}, {23'd0, ctl, alu}, {23'd0, mRw, mMr, mMw, mM2r, mAs, mAlu});
        check({tag, " count"}, cnt, expCnt);
        if (mValid) begin
            check({tag, " A"}, a, mA);
            check({tag, " B"}, b, mB);
            check({tag, " imm"}, imm, mImm);
            check({tag, " regs"}, {17'd0, rs, rt, dest}, {17'd0, mRs, mRt, mDest});
        end
    endtask

    task automatic step();
        logic es;
        @(negedge Clk);
        es = modelStall();
        lastStall = Stall_ID;
        check("stall", 32'(Stall_ID), 32'(es));
        check("sat stall", 32'(sStall_ID), 32'(es));
        @(posedge Clk);
        modelEdge();
        #1;
        checkSet("main", Valid_EX, A_EX, B_EX, Imm_EX, Rs_EX, Rt_EX, Dest_EX,
                 {RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX}, ALUOp_EX,
                 32'(StallCount), satCount(stalls, 65535));
        checkSet("sat", sValid_EX, sA_EX, sB_EX, sImm_EX, sRs_EX, sRt_EX, sDest_EX,
                 {sRegWrite_EX, sMemRead_EX, sMemWrite_EX, sMemToReg_EX, sALUSrc_EX}, sALUOp_EX,
                 32'(sStallCount), satCount(stalls, 7));
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [5:0] ctl, input logic [3:0] alu, input logic wbRw,
                         input logic [4:0] wbReg, input logic [31:0] wbData, input logic fl,
                         input logic vld);
        Instr_ID = instr; ReadData1 = rd1; ReadData2 = rd2;
        {RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID, ALUSrc_ID, RegDst_ID} = ctl;
        ALUOp_ID = alu; WB_RegWrite = wbRw; WB_WriteRegister = wbReg; WB_WriteData = wbData;
        Flush = fl; Valid_ID = vld;
    endtask

    typedef struct {
        logic [31:0] instr, rd1, rd2;
        logic [5:0]  ctl;
        logic [3:0]  alu;
        logic        wbRw;
        logic [4:0]  wbReg;
        logic [31:0] wbData;
        logic        flush, validId;
        logic        expStall, expValid;
        logic [31:0] expA, expB, expImm;
        logic [4:0]  expDest;
        logic        expRw;
        logic [31:0] expCnt;
    } vec_t;

    // ctl = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst}
    localparam logic [5:0] C_R    = 6'b100001;
    localparam logic [5:0] C_LW   = 6'b110110;
    localparam logic [5:0] C_ADDI = 6'b100010;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{rtype(1,2,3), 5, 7, C_R, ALUOP_ADD, 0, 0, 0, 0, 1,
                     0, 1, 5, 7, 32'h1820, 3, 1, 0};
        vecs[1]  = '{rtype(4,0,8), 9, 32'h55, C_R, ALUOP_ADD, 1, 4, 32'hDEAD, 0, 1,
                     0, 1, 32'hDEAD, 0, 32'h4020, 8, 1, 0};
        vecs[2]  = '{rtype(4,0,8), 9, 32'h55, C_R, ALUOP_ADD, 1, 0, 32'hDEAD, 0, 1,
                     0, 1, 9, 0, 32'h4020, 8, 1, 0};
        vecs[3]  = '{itype(6'h23,1,5,16'd4), 100, 11, C_LW, ALUOP_ADD, 0, 0, 0, 0, 1,
                     0, 1, 100, 11, 4, 5, 1, 0};
        vecs[4]  = '{rtype(5,1,6), 20, 30, C_R, ALUOP_ADD, 0, 0, 0, 0, 1,
                     1, 0, 0, 0, 0, 0, 0, 1};
        vecs[5]  = '{rtype(5,1,6), 20, 30, C_R, ALUOP_ADD, 0, 0, 0, 0, 1,
                     0, 1, 20, 30, 32'h3020, 6, 1, 1};
        vecs[6]  = '{itype(6'h23,1,5,16'd4), 100, 11, C_LW, ALUOP_ADD, 0, 0, 0, 0, 1,
                     0, 1, 100, 11, 4, 5, 1, 1};
        vecs[7]  = '{rtype(5,1,6), 20, 30, C_R, ALUOP_ADD, 0, 0, 0, 1, 1,
                     1, 0, 0, 0, 0, 0, 0, 1};
        vecs[8]  = '{itype(6'h08,0,7,16'h8000), 1, 2, C_ADDI, ALUOP_ADD, 0, 0, 0, 0, 1,
                     0, 1, 0, 2, 32'hFFFF8000, 7, 1, 1};
        vecs[9]  = '{rtype(1,2,0), 3, 4, C_R, ALUOP_ADD, 0, 0, 0, 0, 1,
                     0, 1, 3, 4, 32'h0020, 0, 0, 1};
        vecs[10] = '{rtype(1,2,3), 3, 4, C_R, ALUOP_ADD, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 1};

        // Reset state with a valid instruction presented.
        Rst_n = 1'b0;
        drive(rtype(1,2,3), 5, 7, C_R, ALUOP_ADD, 0, 0, 0, 0, 1);
        modelReset();
        #12;
        check("reset valid", 32'(Valid_EX), 0);
        check("reset count", 32'(StallCount), 0);
        check("reset A", A_EX, 0);
        check("reset stall", 32'(Stall_ID), 0);
        @(posedge Clk); #1 Rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].instr, vecs[i].rd1, vecs[i].rd2, vecs[i].ctl, vecs[i].alu, vecs[i].wbRw,
                  vecs[i].wbReg, vecs[i].wbData, vecs[i].flush, vecs[i].validId);
            step();
            check($sformatf("v%0d stall", i), 32'(lastStall), 32'(vecs[i].expStall));
            check($sformatf("v%0d valid", i), 32'(Valid_EX), 32'(vecs[i].expValid));
            check($sformatf("v%0d regwrite", i), 32'(RegWrite_EX), 32'(vecs[i].expRw));
            check($sformatf("v%0d count", i), 32'(StallCount), vecs[i].expCnt);
            if (vecs[i].expValid) begin
                check($sformatf("v%0d A", i), A_EX, vecs[i].expA);
                check($sformatf("v%0d B", i), B_EX, vecs[i].expB);
                check($sformatf("v%0d imm", i), Imm_EX, vecs[i].expImm);
                check($sformatf("v%0d dest", i), 32'(Dest_EX), 32'(vecs[i].expDest));
            end
        end

        // Mid-cycle reset with a load in EX: cleared at once, never replayed.
        drive(itype(6'h23,1,5,16'd4), 100, 11, C_LW, ALUOP_ADD, 0, 0, 0, 0, 1);
        step();
        #2 Rst_n = 1'b0;
        #1;
        check("midreset valid", 32'(Valid_EX), 0);
        check("midreset count", 32'(StallCount), 0);
        check("midreset A", A_EX, 0);
        check("midreset memread", 32'(MemRead_EX), 0);
        check("midreset stall", 32'(Stall_ID), 0);
        modelReset();
        @(posedge Clk); #1 Rst_n = 1'b1;
        check("post reset valid", 32'(Valid_EX), 0);
        drive(rtype(5,1,6), 20, 30, C_R, ALUOP_ADD, 0, 0, 0, 0, 1);
        step();
        check("first cycle stall", 32'(lastStall), 0);

        // Repeated load-use pairs drive the narrow counter into saturation.
        for (int i = 0; i < 9; i++) begin
            drive(itype(6'h23,1,5,16'd4), 100, 11, C_LW, ALUOP_ADD, 0, 0, 0, 0, 1);
            step();
            drive(rtype(5,1,6), 20, 30, C_R, ALUOP_ADD, 0, 0, 0, 0, 1);
            step();
            step();
        end
        check("sat wide count", 32'(StallCount), 9);
        check("sat narrow count", 32'(sStallCount), 7);

        // Random traffic on a small register set so hazards and bypasses are frequent.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] instr;
            instr = $urandom;
            instr[25:21] = 5'($urandom_range(0, 3));
            instr[20:16] = 5'($urandom_range(0, 3));
            instr[15:11] = 5'($urandom_range(0, 3));
            drive(instr, $urandom, $urandom, 6'($urandom), 4'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) != 0));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
